// File: rtl/shift_reg_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a qualified serial stream and
// holds one finished word for a valid/ready consumer, flagging words lost to back-pressure.
module shift_reg_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             S_IN,
    input  logic             S_VALID,
    input  logic             S_START,
    output logic [WIDTH-1:0] Q,
    output logic             Q_VALID,
    input  logic             Q_READY,
    output logic             BUSY,
    output logic             OVERRUN,
    input  logic             CLR_OVR
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastIdx = CW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_shift, w_shift_d;
    logic [CW-1:0]    r_count, w_count_d;
    logic [WIDTH-1:0] r_q, w_q_d;
    logic             r_q_valid, w_q_valid_d;
    logic             r_overrun, w_overrun_d;

    logic             w_capture;
    logic             w_restart;
    logic [CW-1:0]    w_k;
    int               w_pos;
    logic [WIDTH-1:0] w_word;
    logic             w_done;

    // A start bit always begins a fresh word, whether idle or mid-word.
    assign w_restart = S_VALID && S_START;
    assign w_capture = S_VALID && (S_START || (r_state == StShift));
    assign w_k       = w_restart ? '0 : r_count;
    assign w_done    = w_capture && !w_restart && (w_k == LastIdx);

    always_comb begin
        w_pos = (MSB_FIRST != 0) ? (int'(WIDTH) - 1 - int'(w_k)) : int'(w_k);
        w_word = w_restart ? '0 : r_shift;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i == w_pos) begin
                w_word[i] = S_IN;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_shift_d = r_shift;
        w_count_d = r_count;
        if (w_capture) begin
            if (w_done) begin
                w_state_d = StIdle;
                w_shift_d = '0;
                w_count_d = '0;
            end else begin
                w_state_d = StShift;
                w_shift_d = w_word;
                w_count_d = w_k + 1'b1;
            end
        end
    end

    always_comb begin
        w_q_d       = r_q;
        w_q_valid_d = r_q_valid;
        w_overrun_d = r_overrun;
        if (CLR_OVR) begin
            w_overrun_d = 1'b0;
        end
        if (w_done) begin
            // Consume and load on the same edge is lossless.
            if (!r_q_valid || Q_READY) begin
                w_q_d       = w_word;
                w_q_valid_d = 1'b1;
            end else begin
                w_overrun_d = 1'b1;
            end
        end else if (r_q_valid && Q_READY) begin
            w_q_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_count   <= '0;
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_count   <= w_count_d;
            r_q       <= w_q_d;
            r_q_valid <= w_q_valid_d;
            r_overrun <= w_overrun_d;
        end
    end

    assign Q       = r_q;
    assign Q_VALID = r_q_valid;
    assign BUSY    = (r_state == StShift);
    assign OVERRUN = r_overrun;

endmodule

// File: tb/tb_shift_reg_deserializer.sv
// Directed bench for shift_reg_deserializer: an LSB-first and an MSB-first instance share
// one serial stream; expected values are hand-computed constants.
module tb_shift_reg_deserializer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       S_IN = 1'b0;
    logic       S_VALID = 1'b0;
    logic       S_START = 1'b0;
    logic       Q_READY = 1'b0;
    logic       CLR_OVR = 1'b0;

    logic [3:0] q_lsb, q_msb;
    logic       qv_lsb, qv_msb;
    logic       busy_lsb, busy_msb;
    logic       ovr_lsb, ovr_msb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    shift_reg_deserializer #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .CLK     (CLK),
        .RESET   (RESET),
        .S_IN    (S_IN),
        .S_VALID (S_VALID),
        .S_START (S_START),
        .Q       (q_lsb),
        .Q_VALID (qv_lsb),
        .Q_READY (Q_READY),
        .BUSY    (busy_lsb),
        .OVERRUN (ovr_lsb),
        .CLR_OVR (CLR_OVR)
    );

    shift_reg_deserializer #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .CLK     (CLK),
        .RESET   (RESET),
        .S_IN    (S_IN),
        .S_VALID (S_VALID),
        .S_START (S_START),
        .Q       (q_msb),
        .Q_VALID (qv_msb),
        .Q_READY (Q_READY),
        .BUSY    (busy_msb),
        .OVERRUN (ovr_msb),
        .CLR_OVR (CLR_OVR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        S_VALID = 1'b1;
        S_IN    = b;
        S_START = st;
        tick();
        S_VALID = 1'b0;
        S_START = 1'b0;
        S_IN    = 1'b0;
    endtask

    // Bits are sent in index order 0..3 of the argument (LSB-first meaning).
    task automatic send_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) begin
            send_bit(w[i], i == 0);
        end
    endtask

    initial begin
        // Reset then idle
        tick();
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_q", 32'(q_lsb), 32'h0);
            check("idle_qv", 32'(qv_lsb), 32'h0);
            check("idle_busy", 32'(busy_lsb), 32'h0);
            check("idle_ovr", 32'(ovr_lsb), 32'h0);
        end

        // LSB-first word 1,0,1,1 with consumer ready
        Q_READY = 1'b1;
        send_bit(1'b1, 1'b1);
        check("lsb_busy_b2", 32'(busy_lsb), 32'h1);
        send_bit(1'b0, 1'b0);
        check("lsb_busy_b3", 32'(busy_lsb), 32'h1);
        send_bit(1'b1, 1'b0);
        check("lsb_busy_b4", 32'(busy_lsb), 32'h1);
        check("lsb_qv_early", 32'(qv_lsb), 32'h0);
        send_bit(1'b1, 1'b0);
        check("lsb_q", 32'(q_lsb), 32'hD);
        check("lsb_qv", 32'(qv_lsb), 32'h1);
        tick();
        check("lsb_qv_drop", 32'(qv_lsb), 32'h0);
        check("lsb_q_hold", 32'(q_lsb), 32'hD);

        // Same bits with two idle cycles between each; MSB-first instance gives 1011
        send_bit(1'b1, 1'b1);
        tick();
        tick();
        check("gap_busy", 32'(busy_msb), 32'h1);
        send_bit(1'b0, 1'b0);
        tick();
        tick();
        send_bit(1'b1, 1'b0);
        tick();
        tick();
        check("gap_qv_early", 32'(qv_msb), 32'h0);
        send_bit(1'b1, 1'b0);
        check("msb_q", 32'(q_msb), 32'hB);
        check("msb_qv", 32'(qv_msb), 32'h1);
        check("gap_lsb_q", 32'(q_lsb), 32'hD);
        tick();

        // Back-pressure overrun
        Q_READY = 1'b0;
        send_word(4'h3);
        check("ovr_q_first", 32'(q_lsb), 32'h3);
        check("ovr_qv_first", 32'(qv_lsb), 32'h1);
        check("ovr_flag_clear", 32'(ovr_lsb), 32'h0);
        send_word(4'hC);
        check("ovr_q_kept", 32'(q_lsb), 32'h3);
        check("ovr_qv_kept", 32'(qv_lsb), 32'h1);
        check("ovr_flag_set", 32'(ovr_lsb), 32'h1);
        tick();
        check("ovr_sticky", 32'(ovr_lsb), 32'h1);
        CLR_OVR = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        check("clr_ovr", 32'(ovr_lsb), 32'h0);
        check("clr_q", 32'(q_lsb), 32'h3);
        check("clr_qv", 32'(qv_lsb), 32'h1);

        // Clear on the same edge as a new drop: set wins
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        CLR_OVR = 1'b1;
        send_bit(1'b1, 1'b0);
        CLR_OVR = 1'b0;
        check("clr_vs_drop", 32'(ovr_lsb), 32'h1);
        check("clr_vs_drop_q", 32'(q_lsb), 32'h3);

        // Simultaneous consume and load
        CLR_OVR = 1'b1;
        Q_READY = 1'b1;
        tick();
        CLR_OVR = 1'b0;
        Q_READY = 1'b0;
        check("sim_drained", 32'(qv_lsb), 32'h0);
        send_word(4'h5);
        check("sim_q5", 32'(q_lsb), 32'h5);
        check("sim_qv5", 32'(qv_lsb), 32'h1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        Q_READY = 1'b1;
        send_bit(1'b1, 1'b0);
        Q_READY = 1'b0;
        check("sim_qA", 32'(q_lsb), 32'hA);
        check("sim_qvA", 32'(qv_lsb), 32'h1);
        check("sim_ovr", 32'(ovr_lsb), 32'h0);
        Q_READY = 1'b1;
        tick();
        Q_READY = 1'b0;

        // Restart mid-word: two bits then a fresh start with 0,1,1,0
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("rst_word_pending", 32'(qv_lsb), 32'h0);
        send_bit(1'b0, 1'b0);
        check("restart_q", 32'(q_lsb), 32'h6);
        check("restart_qv", 32'(qv_lsb), 32'h1);
        check("restart_ovr", 32'(ovr_lsb), 32'h0);

        // Async reset between edges with a buffered word and a partial word
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        check("pre_rst_busy", 32'(busy_lsb), 32'h1);
        check("pre_rst_qv", 32'(qv_lsb), 32'h1);
        #2;
        RESET = 1'b1;
        #1;
        check("async_busy", 32'(busy_lsb), 32'h0);
        check("async_qv", 32'(qv_lsb), 32'h0);
        check("async_q", 32'(q_lsb), 32'h0);
        tick();
        RESET = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy_lsb), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_reg_deserializer.md
Name: shift_reg_deserializer

Overview:
- Receive end of the 4-bit shifting register's serial output: collects bits from S_OUT/S_IN-style serial lines into parallel words.
- Buffers one completed word for a downstream consumer through a valid/ready handshake.
- Flags words lost to back-pressure.
- Sits after the shifting register in the top level and feeds parallel data back to the testbench and checker logic.

Parameters:
- WIDTH, 4, bits per word (≥2).
- MSB_FIRST, 0: 0 = first received bit lands in Q[0]; 1 = first received bit lands in Q[WIDTH-1].

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset.
- S_IN  input  1  serial data bit.
- S_VALID  input  1  S_IN is sampled on CLK rising edge when high.
- S_START  input  1  marks the first bit of a word; qualified by S_VALID.
- Q  output  WIDTH  parallel word in the output buffer.
- Q_VALID  output  1  Q holds an unconsumed word.
- Q_READY  input  1  consumer accepts Q on a rising edge when Q_VALID && Q_READY.
- BUSY  output  1  a word is partially assembled.
- OVERRUN  output  1  sticky: a completed word was dropped.
- CLR_OVR  input  1  synchronous clear of OVERRUN.

Behaviour:
- Reset (async, immediate): state = IDLE, shift register = 0, bit count = 0, Q = 0, Q_VALID = 0, BUSY = 0, OVERRUN = 0. Reset mid-word discards the partial word and any buffered word.
- States: IDLE, SHIFT.
- IDLE:
  - S_VALID && S_START: capture S_IN as bit 0 of the word, count = 1, go to SHIFT.
  - S_VALID without S_START: ignored.
  - BUSY = 0.
- SHIFT (BUSY = 1):
  - Each S_VALID cycle captures S_IN and increments count.
  - When the WIDTH-th bit is captured, the word completes and the state returns to IDLE the next cycle.
  - Cycles with S_VALID low hold state (gaps allowed).
  - S_VALID && S_START in SHIFT: abort the partial word, restart with S_IN as bit 0, count = 1, no flag.
- Bit placement:
  - MSB_FIRST = 0: k-th received bit (k = 0..WIDTH-1) goes to position k.
  - MSB_FIRST = 1: k-th received bit goes to position WIDTH-1-k.
- Completion / output buffer:
  - Completion happens on the edge that captures the last bit. Q and Q_VALID update on that same edge, so latency from the last bit's sampling edge to Q_VALID = 1 is one clock edge.
  - If Q_VALID = 0, or Q_VALID && Q_READY on that same edge: load Q, Q_VALID = 1. Simultaneous consume-and-load is lossless.
  - Otherwise the new word is dropped, Q/Q_VALID keep the old word, and OVERRUN is set.
  - Handshake: Q_VALID && Q_READY with no completing word → Q_VALID = 0 next edge. Q stays stable (retains the last value) while Q_VALID = 0 and while Q_VALID is waiting on Q_READY.
- OVERRUN:
  - Set on a drop; cleared only by RESET or CLR_OVR.
  - CLR_OVR on the same edge as a new drop: set wins.
- WIDTH = 1 start-only word not supported (WIDTH ≥ 2).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then idle:
  - Stimulus: hold RESET 2 cycles, release, no S_VALID.
  - Required: Q = 4'b0000, Q_VALID = 0, BUSY = 0, OVERRUN = 0 throughout.
- LSB-first word (MSB_FIRST = 0):
  - Stimulus: send bits 1,0,1,1 with S_START on the first bit, then hold Q_READY = 1.
  - Required: BUSY high during bits 2–4. On the edge capturing the 4th bit, Q = 4'b1101 and Q_VALID = 1. Q_VALID drops the next edge.
- MSB-first with gaps (MSB_FIRST = 1):
  - Stimulus: send bits 1,0,1,1 with 2 idle cycles between bits.
  - Required: Q = 4'b1011, Q_VALID = 1.
- Back-pressure overrun:
  - Stimulus: Q_READY = 0; send word 4'h3, then word 4'hC.
  - Required: Q stays 4'h3, Q_VALID = 1, OVERRUN = 1.
  - Then pulse CLR_OVR: OVERRUN = 0, Q still 4'h3.
- Simultaneous consume and load:
  - Stimulus: Q holds 4'h5 with Q_VALID = 1; assert Q_READY exactly on the edge completing word 4'hA.
  - Required: Q = 4'hA, Q_VALID = 1, OVERRUN = 0.
- Restart and async reset:
  - Stimulus: after 2 bits, assert S_START with bits 0,1,1,0.
  - Required: Q = 4'b0110 (LSB-first), no OVERRUN.
  - Stimulus: assert RESET mid-word between clock edges.
  - Required: BUSY = 0 and Q_VALID = 0 immediately, without waiting for a clock edge.
